// File: rtl/alut_pkg12.sv
// ALUT age checker shared definitions.
// Entry layout, table geometry and sweep FSM encoding.
package alut_pkg12;

  localparam int ALUT_DW = 83;
  localparam int ALUT_DD = 256;
  localparam int ALUT_AW = 8;

  localparam int VLD_BIT = 82;
  localparam int TS_HI   = 81;
  localparam int TS_LO   = 50;
  localparam int PORT_HI = 49;
  localparam int PORT_LO = 48;
  localparam int MAC_HI  = 47;
  localparam int MAC_LO  = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_CHECK = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } age_st_e;

endpackage

// File: rtl/alut_age_cmp12.sv
// Wrap-safe entry age comparison.
// An entry is stale when valid and strictly older than the limit.
module alut_age_cmp12 (
  input  logic        vld_i,
  input  logic [31:0] now_i,
  input  logic [31:0] ts_i,
  input  logic [31:0] max_age_i,
  output logic        aged_o
);

  logic [31:0] age;

  // Modulo-2^32 subtract keeps ages correct across timer wrap
  assign age    = now_i - ts_i;
  assign aged_o = vld_i && (age > max_age_i);

endmodule

// File: rtl/alut_age_checker12.sv
// ALUT age sweeper: walks every entry, invalidating stale ones.
// Yields the RAM port to the address checker whenever it is active.
module alut_age_checker12
  import alut_pkg12::*;
#(
  parameter int DW12 = ALUT_DW,
  parameter int DD12 = ALUT_DD
) (
  input  logic               pclk12,
  input  logic               p_reset12,
  input  logic               start_sweep12,
  input  logic [31:0]        curr_time12,
  input  logic [31:0]        best_bfr_age12,
  input  logic               add_check_active12,
  input  logic [DW12-1:0]    mem_read_data_age12,
  output logic [ALUT_AW-1:0] mem_addr_age12,
  output logic               mem_write_age12,
  output logic [DW12-1:0]    mem_write_data_age12,
  output logic               age_busy12,
  output logic               age_done12,
  output logic [8:0]         aged_count12
);

  localparam logic [ALUT_AW-1:0] LAST =
    ALUT_AW'(DD12 - 1);
  localparam logic [DW12-1:0] VLD_MASK =
    ~(DW12'(1) << VLD_BIT);

  age_st_e            st_q, st_d;
  logic [ALUT_AW-1:0] addr_q, addr_d;
  logic [8:0]         cnt_q, cnt_d;
  logic [31:0]        time_q, time_d;
  logic [31:0]        max_q, max_d;
  logic [DW12-1:0]    wdat_q, wdat_d;
  logic               aged;
  logic               last;

  assign last = (addr_q == LAST);

  alut_age_cmp12 u_cmp (
    .vld_i     (mem_read_data_age12[VLD_BIT]),
    .now_i     (time_q),
    .ts_i      (mem_read_data_age12[TS_HI:TS_LO]),
    .max_age_i (max_q),
    .aged_o    (aged)
  );

  always_ff @(posedge pclk12 or posedge p_reset12) begin
    if (p_reset12) begin
      st_q   <= ST_IDLE;
      addr_q <= '0;
      cnt_q  <= '0;
      time_q <= '0;
      max_q  <= '0;
      wdat_q <= '0;
    end else begin
      st_q   <= st_d;
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
      time_q <= time_d;
      max_q  <= max_d;
      wdat_q <= wdat_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    addr_d = addr_q;
    cnt_d  = cnt_q;
    time_d = time_q;
    max_d  = max_q;
    wdat_d = wdat_q;
    unique case (st_q)
      ST_IDLE: begin
        if (start_sweep12) begin
          time_d = curr_time12;
          max_d  = best_bfr_age12;
          cnt_d  = '0;
          addr_d = '0;
          st_d   = ST_READ;
        end
      end
      ST_READ: begin
        if (!add_check_active12) st_d = ST_CHECK;
      end
      ST_CHECK: begin
        wdat_d = mem_read_data_age12 & VLD_MASK;
        if (aged) begin
          st_d = ST_WRITE;
        end else if (last) begin
          st_d = ST_DONE;
        end else begin
          addr_d = addr_q + 8'd1;
          st_d   = ST_READ;
        end
      end
      ST_WRITE: begin
        // Write lands on the cycle the address checker releases the RAM
        if (!add_check_active12) begin
          cnt_d = cnt_q + 9'd1;
          if (last) begin
            st_d = ST_DONE;
          end else begin
            addr_d = addr_q + 8'd1;
            st_d   = ST_READ;
          end
        end
      end
      ST_DONE: st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
  end

  assign mem_addr_age12       = addr_q;
  assign mem_write_age12      = (st_q == ST_WRITE) &&
                                !add_check_active12;
  assign mem_write_data_age12 = wdat_q;
  assign age_busy12           = (st_q == ST_READ)  ||
                                (st_q == ST_CHECK) ||
                                (st_q == ST_WRITE);
  assign age_done12           = (st_q == ST_DONE);
  assign aged_count12         = cnt_q;

endmodule
